// File: rtl/product_bcd_converter.sv
// Converts an 8-bit two's-complement product into sign + three BCD digits
// using a sequential double-dabble (one shift per clock, 8 shifts total).
module product_bcd_converter (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] prod,
    output logic       busy,
    output logic       done,
    output logic       sign,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] units
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic        neg_q;
    logic [7:0]  mag_q;
    logic [11:0] scratch_q;
    logic [2:0]  cnt_q;

    logic [10:0] adj;
    logic [11:0] scratch_d;
    logic [7:0]  mag_d;

    // One double-dabble step. The hundreds nibble only needs its low three
    // bits after the adjust, because its top bit is shifted out.
    always_comb begin
        adj       = '0;
        adj[3:0]  = (scratch_q[3:0] >= 4'd5) ? scratch_q[3:0] + 4'd3 : scratch_q[3:0];
        adj[7:4]  = (scratch_q[7:4] >= 4'd5) ? scratch_q[7:4] + 4'd3 : scratch_q[7:4];
        adj[10:8] = (scratch_q[11:8] >= 4'd5) ? scratch_q[10:8] + 3'd3 : scratch_q[10:8];
        scratch_d = {adj, mag_q[7]};
        mag_d     = {mag_q[6:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            neg_q     <= 1'b0;
            mag_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sign      <= 1'b0;
            hundreds  <= '0;
            tens      <= '0;
            units     <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        neg_q     <= prod[7];
                        // -128 negates to 8'h80, which is 128 read as unsigned.
                        mag_q     <= prod[7] ? (~prod + 8'd1) : prod;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        busy      <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_q <= scratch_d;
                    mag_q     <= mag_d;
                    cnt_q     <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    hundreds <= scratch_q[11:8];
                    tens     <= scratch_q[7:4];
                    units    <= scratch_q[3:0];
                    sign     <= neg_q;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed and exhaustive checks of product_bcd_converter: latency, done
// width, busy, start-while-busy, back-to-back, and reset behaviour.
module tb_product_bcd_converter;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] prod;
    logic       busy;
    logic       done;
    logic       sign;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] units;

    int n_checks;
    int n_errors;
    logic [12:0] snap;

    product_bcd_converter dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .prod     (prod),
        .busy     (busy),
        .done     (done),
        .sign     (sign),
        .hundreds (hundreds),
        .tens     (tens),
        .units    (units)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] out_now();
        return {sign, hundreds, tens, units};
    endfunction

    // Reference: sign plus decimal digits of |prod|, computed arithmetically.
    function automatic logic [12:0] ref_bcd(input logic [7:0] p);
        int m;
        m = p[7] ? (256 - int'(p)) : int'(p);
        return {p[7], 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    // Accept edge (edge 0); prod is scrambled afterwards to prove it is
    // only sampled on the accepting edge.
    task automatic launch(input logic [7:0] p, input string tag);
        snap  = out_now();
        start = 1'b1;
        prod  = p;
        tick();
        start = 1'b0;
        prod  = 8'($urandom_range(0, 255));
        check({tag, "/busy0"}, 32'(busy), 32'd1);
        check({tag, "/done_fall"}, 32'(done), 32'd0);
    endtask

    task automatic finish(input logic [12:0] exp, input int from, input string tag);
        int lat;
        lat = 0;
        for (int i = from + 1; i <= 20; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
            check({tag, "/busy_run"}, 32'(busy), 32'd1);
            check({tag, "/hold"}, 32'(out_now()), 32'(snap));
        end
        check({tag, "/latency"}, 32'(lat), 32'd9);
        check({tag, "/busy_end"}, 32'(busy), 32'd0);
        check({tag, "/result"}, 32'(out_now()), 32'(exp));
    endtask

    initial begin
        int dones;
        n_checks = 0;
        n_errors = 0;

        // Reset with start held high: reset must win.
        rst   = 1'b1;
        start = 1'b1;
        prod  = 8'h55;
        tick();
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/done", 32'(done), 32'd0);
        check("rst/outs", 32'(out_now()), 32'd0);
        tick();
        check("rst/idle", 32'(busy), 32'd0);

        launch(8'h79, "p79");
        finish(13'h0121, 0, "p79");
        launch(8'h80, "p80");
        finish(13'h1128, 0, "p80");
        tick();
        check("p80/done_w", 32'(done), 32'd0);
        tick();
        launch(8'hF7, "pF7");
        finish(13'h1009, 0, "pF7");
        launch(8'h00, "p00");
        finish(13'h0000, 0, "p00");
        tick();
        tick();

        // Second start at edge 4 must be ignored.
        launch(8'h2A, "busy");
        tick();
        tick();
        tick();
        start = 1'b1;
        prod  = 8'h10;
        tick();
        start = 1'b0;
        finish(13'h0042, 4, "busy");
        dones = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (done) dones++;
        end
        check("busy/extra_done", 32'(dones), 32'd0);
        check("busy/outs_kept", 32'(out_now()), 32'h0042);
        check("busy/idle", 32'(busy), 32'd0);

        // Back-to-back: start issued in the done cycle.
        launch(8'h79, "b2b_a");
        finish(13'h0121, 0, "b2b_a");
        launch(8'hC4, "b2b");
        finish(13'h1060, 0, "b2b");

        // Reset at edge 5 aborts the conversion.
        launch(8'h63, "abort");
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort/busy", 32'(busy), 32'd0);
        check("abort/done", 32'(done), 32'd0);
        check("abort/outs", 32'(out_now()), 32'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dones++;
        end
        check("abort/no_done", 32'(dones), 32'd0);
        check("abort/outs_hold", 32'(out_now()), 32'd0);

        // Exhaustive sweep, back-to-back; first start after reset included.
        for (int p = 0; p < 256; p++) begin
            launch(8'(p), "sweep");
            finish(ref_bcd(8'(p)), 0, $sformatf("sweep%0d", p));
        end
        tick();
        check("sweep/done_w", 32'(done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
